// File: rtl/spi_bridge_pkg.sv
// Shared constants and types for the SPI-to-register-file bridge.
// Frame layout: 16-bit header {rw, rsvd[2:0], mask[3:0], rsvd[2:0], addr[4:0]} then 32 data bits.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DATA    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int unsigned HDR_BITS   = 16;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned FRAME_BITS = HDR_BITS + DATA_BITS;
  localparam int unsigned CNT_W      = 6;

  // Header field positions within the 16-bit header word
  localparam int unsigned HDR_RW_BIT   = 15;
  localparam int unsigned HDR_MASK_LSB = 8;
  localparam int unsigned HDR_ADDR_LSB = 0;

  // Register-file geometry
  localparam int unsigned RF_AWIDTH_DEF = 5;
  localparam int unsigned RF_WIDTH_DEF  = 32;
  localparam int unsigned RF_MASK_DEF   = RF_WIDTH_DEF / 8;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for one asynchronous input, with a selectable reset level.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {STAGES{RESET_VAL}};
    else     r_sync <= STAGES'({r_sync, i_d});
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_regfile_bridge.sv
// SPI mode-0 target, oversampled in clk, that turns 48-bit host frames into
// single-cycle register-file reads and masked writes.
module spi_regfile_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned RF_AWIDTH   = RF_AWIDTH_DEF,
  parameter int unsigned RF_WIDTH    = RF_WIDTH_DEF,
  parameter int unsigned RF_MASK     = RF_MASK_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 we,
  output logic [RF_AWIDTH-1:0] addr,
  output logic [RF_WIDTH-1:0]  wdata,
  output logic [RF_MASK-1:0]   wmask,
  input  logic [RF_WIDTH-1:0]  rdata,
  output logic                 frame_err
);

  logic w_sclk_s, w_cs_n_s, w_mosi_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(spi_sclk), .o_q(w_sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst(rst), .i_d(spi_cs_n), .o_q(w_cs_n_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(spi_mosi), .o_q(w_mosi_s));

  logic r_sclk_d, r_cs_n_d;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = r_cs_n_d & ~w_cs_n_s;

  // Synchronizers hold their reset level for a few clocks, so a CS already low
  // at reset release must not look like a fresh falling edge.
  logic [SYNC_STAGES:0] r_warm;
  logic                 r_armed;

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt, w_cnt_nxt;
  logic [RF_WIDTH-1:0]  r_shift_in, w_sin_nxt, w_shift_in;
  logic [RF_WIDTH-1:0]  r_shift_out, w_sout_nxt;
  logic                 r_rw, w_rw_nxt;
  logic [RF_MASK-1:0]   r_hdr_mask, w_hmask_nxt;
  logic [RF_AWIDTH-1:0] r_hdr_addr, w_haddr_nxt;
  logic [RF_AWIDTH-1:0] r_addr, w_addr_nxt;
  logic [RF_WIDTH-1:0]  r_wdata, w_wdata_nxt;
  logic [RF_MASK-1:0]   r_wmask, w_wmask_nxt;
  logic                 r_we, w_we_nxt;
  logic                 r_miso, w_miso_nxt;
  logic                 r_miso_oe;
  logic                 r_frame_err, w_err_nxt;

  assign w_shift_in = {r_shift_in[RF_WIDTH-2:0], w_mosi_s};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_sin_nxt   = r_shift_in;
    w_sout_nxt  = r_shift_out;
    w_rw_nxt    = r_rw;
    w_hmask_nxt = r_hdr_mask;
    w_haddr_nxt = r_hdr_addr;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wmask_nxt = r_wmask;
    w_we_nxt    = 1'b0;
    w_miso_nxt  = r_miso;
    w_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_miso_nxt = 1'b0;
        if (r_armed && w_cs_fall) begin
          w_state_nxt = ST_HDR;
          w_cnt_nxt   = '0;
          w_sout_nxt  = '0;
        end
      end
      ST_HDR: begin
        w_miso_nxt = 1'b0;
        if (w_sclk_rise) begin
          w_sin_nxt = w_shift_in;
          w_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(HDR_BITS - 1)) begin
            w_rw_nxt    = w_shift_in[HDR_RW_BIT];
            w_hmask_nxt = w_shift_in[HDR_MASK_LSB +: RF_MASK];
            w_haddr_nxt = w_shift_in[HDR_ADDR_LSB +: RF_AWIDTH];
            if (w_shift_in[HDR_RW_BIT]) begin
              w_state_nxt = ST_DATA;
            end else begin
              // Present the read address immediately so rdata is ready two clocks later
              w_addr_nxt  = w_shift_in[HDR_ADDR_LSB +: RF_AWIDTH];
              w_state_nxt = ST_RD_REQ;
            end
          end
        end
      end
      ST_RD_REQ: begin
        w_addr_nxt  = r_hdr_addr;
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_sout_nxt  = rdata;
        w_miso_nxt  = rdata[RF_WIDTH-1];
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_sclk_rise) begin
          w_sin_nxt = w_shift_in;
          w_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            w_state_nxt = ST_DONE;
            if (r_rw) begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = r_hdr_addr;
              w_wdata_nxt = w_shift_in;
              w_wmask_nxt = r_hdr_mask;
            end
          end
        end else if (w_sclk_fall && (r_bit_cnt != CNT_W'(HDR_BITS))) begin
          // The fall right after the last header bit keeps bit 31 on MISO
          w_sout_nxt = {r_shift_out[RF_WIDTH-2:0], 1'b0};
          w_miso_nxt = r_shift_out[RF_WIDTH-2];
        end
      end
      ST_DONE: begin
        if (w_cs_n_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_cs_n_s && (r_state inside {ST_HDR, ST_RD_REQ, ST_RD_WAIT, ST_DATA})) begin
      w_state_nxt = ST_IDLE;
      w_we_nxt    = 1'b0;
      w_miso_nxt  = 1'b0;
      w_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_d    <= 1'b0;
      r_cs_n_d    <= 1'b1;
      r_warm      <= '0;
      r_armed     <= 1'b0;
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_rw        <= 1'b0;
      r_hdr_mask  <= '0;
      r_hdr_addr  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_we        <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_d    <= w_sclk_s;
      r_cs_n_d    <= w_cs_n_s;
      r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};
      r_armed     <= r_armed | (r_warm[SYNC_STAGES] & w_cs_n_s);
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_shift_in  <= w_sin_nxt;
      r_shift_out <= w_sout_nxt;
      r_rw        <= w_rw_nxt;
      r_hdr_mask  <= w_hmask_nxt;
      r_hdr_addr  <= w_haddr_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wmask     <= w_wmask_nxt;
      r_we        <= w_we_nxt;
      r_miso      <= w_miso_nxt;
      r_miso_oe   <= ~w_cs_n_s;
      r_frame_err <= w_err_nxt;
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign we          = r_we;
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign wmask       = r_wmask;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_regfile_bridge.sv
// Scoreboard bench for spi_regfile_bridge: an SPI host task issues frames, a
// register-file model answers reads, and monitors check we/frame_err/read data.
module tb_spi_regfile_bridge;

  localparam int HALF = 10;
  localparam logic [31:0] CHIP_ID = 32'hC41D_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        frame_err;

  spi_regfile_bridge dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .we(we), .addr(addr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  int          exp_err_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rx_word;
  event        rd_done;

  // Register-file model: registered read, byte-masked write, address 0 is a read-only ID
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0]  = CHIP_ID;
    mem[1]  = 32'd15;
    mem[27] = 32'h3FF;
  end
  always @(posedge clk) begin
    rdata <= mem[addr];
    if (we && addr != 5'd0)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write and abort monitor
  always @(negedge clk) begin
    if (!rst && we) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_we: addr=%0d wdata=%h wmask=%h", addr, wdata, wmask);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        if (addr !== e.a || wdata !== e.d || wmask !== e.m) begin
          n_fail++;
          $display("FAIL write: got addr=%0d wdata=%h wmask=%h expected addr=%0d wdata=%h wmask=%h",
                   addr, wdata, wmask, e.a, e.d, e.m);
        end
      end
    end
    if (!rst && frame_err) begin
      n_checks++;
      if (exp_err_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame_err: got 1 expected 0");
      end else begin
        void'(exp_err_q.pop_front());
      end
    end
  end

  // Read-data monitor
  always @(rd_done) begin
    n_checks++;
    if (exp_rd_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_read: got %h", rx_word);
    end else begin
      logic [31:0] e;
      e = exp_rd_q.pop_front();
      if (rx_word !== e) begin
        n_fail++;
        $display("FAIL read_data: got %h expected %h", rx_word, e);
      end
    end
  end

  function automatic logic [47:0] mk(input logic rw, input logic [3:0] m,
                                     input logic [4:0] a, input logic [31:0] d);
    return {rw, 3'b000, m, 3'b000, a, d};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI mode-0 host: nbits clocks, bits past 48 send 1s; keep_cs leaves CS low at the end
  task automatic spi_xfer(input logic [47:0] frame, input int nbits, input bit keep_cs,
                          input bit is_read);
    logic [31:0] rx;
    rx = '0;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 48) ? frame[47 - i] : 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b1;
      if (i >= 16 && i < 48) rx = {rx[30:0], spi_miso};
      if (i == 8) begin
        check("hdr_miso_zero", {31'b0, spi_miso}, 32'h0);
        check("miso_oe_active", {31'b0, spi_miso_oe}, 32'h1);
      end
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
    wait_clk(HALF);
    if (!keep_cs) begin
      spi_cs_n = 1'b1;
      wait_clk(4);
    end
    if (is_read) begin
      rx_word = rx;
      -> rd_done;
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_t e;
    e.a = a; e.d = d; e.m = m;
    exp_wr_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},        {31'b0, we},          32'h0);
    check({tag, "_addr"},      {27'b0, addr},        32'h0);
    check({tag, "_wdata"},     wdata,                32'h0);
    check({tag, "_wmask"},     {28'b0, wmask},       32'h0);
    check({tag, "_miso"},      {31'b0, spi_miso},    32'h0);
    check({tag, "_miso_oe"},   {31'b0, spi_miso_oe}, 32'h0);
    check({tag, "_frame_err"}, {31'b0, frame_err},   32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wait_clk(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(10);

    // Full-mask write
    push_wr(5'd28, 32'h0000_0AAA, 4'hF);
    spi_xfer(mk(1'b1, 4'hF, 5'd28, 32'h0000_0AAA), 48, 1'b0, 1'b0);

    // Byte-masked write
    push_wr(5'd0, 32'h0000_0100, 4'h2);
    spi_xfer(mk(1'b1, 4'h2, 5'd0, 32'h0000_0100), 48, 1'b0, 1'b0);

    // Reads
    exp_rd_q.push_back(32'h0000_000F);
    spi_xfer(mk(1'b0, 4'h0, 5'd1, 32'h0), 48, 1'b0, 1'b1);
    exp_rd_q.push_back(32'h0000_03FF);
    spi_xfer(mk(1'b0, 4'h0, 5'd27, 32'h0), 48, 1'b0, 1'b1);

    // Abort after 30 bits, then a normal write
    exp_err_q.push_back(1);
    spi_xfer(mk(1'b1, 4'hF, 5'd5, 32'hDEAD_BEEF), 30, 1'b0, 1'b0);
    push_wr(5'd3, 32'h1234_5678, 4'hF);
    spi_xfer(mk(1'b1, 4'hF, 5'd3, 32'h1234_5678), 48, 1'b0, 1'b0);

    // Reset during the data phase of a write, CS still low
    spi_xfer(mk(1'b1, 4'hF, 5'd4, 32'h5555_AAAA), 30, 1'b1, 1'b0);
    rst = 1'b1;
    wait_clk(1);
    check_reset_outputs("midrst");
    wait_clk(4);
    rst = 1'b0;
    wait_clk(10);
    spi_cs_n = 1'b1;
    wait_clk(10);
    exp_rd_q.push_back(CHIP_ID);
    spi_xfer(mk(1'b0, 4'h0, 5'd0, 32'h0), 48, 1'b0, 1'b1);

    // Back-to-back: reserved header bits set, then mask=0, then over-clocked frame
    push_wr(5'd7, 32'h1111_1111, 4'h1);
    spi_xfer({16'hF1E7, 32'h1111_1111}, 48, 1'b0, 1'b0);
    push_wr(5'd8, 32'h2222_2222, 4'h0);
    spi_xfer(mk(1'b1, 4'h0, 5'd8, 32'h2222_2222), 48, 1'b0, 1'b0);
    push_wr(5'd9, 32'hCAFE_F00D, 4'hC);
    spi_xfer(mk(1'b1, 4'hC, 5'd9, 32'hCAFE_F00D), 60, 1'b0, 1'b0);

    // Read back a masked write through the model to confirm byte lanes
    exp_rd_q.push_back(32'hCAFE_0000);
    spi_xfer(mk(1'b0, 4'h0, 5'd9, 32'h0), 48, 1'b0, 1'b1);

    wait_clk(20);
    check("pending_writes", 32'(exp_wr_q.size()), 32'h0);
    check("pending_frame_err", 32'(exp_err_q.size()), 32'h0);
    check("pending_reads", 32'(exp_rd_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
